// File: rtl/ad7606_pkg.sv
// rtl/ad7606_pkg.sv - shared types and constants for the AD7606 sample scheduler
// Contents:
//   state_t    sequencer states (IDLE, CFG, WAIT, CAP)
//   OS_LSB     config-word position of the oversampling code
//   RANGE_BIT  config-word position of the range select
//   CH_IDX_W   width of a channel index
//   cfg_word() builds the 16-bit config word sent to the core
package ad7606_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAP  = 2'd3
  } state_t;

  localparam int OS_LSB    = 0;
  localparam int RANGE_BIT = 3;
  localparam int CH_IDX_W  = 3;

  function automatic logic [15:0] cfg_word(input logic [2:0] os, input logic rng);
    logic [15:0] w;
    w = '0;
    w[OS_LSB +: 3] = os;
    w[RANGE_BIT]   = rng;
    return w;
  endfunction

endpackage

// File: rtl/ad7606_period_gen.sv
// rtl/ad7606_period_gen.sv - sample-period counter with divider latch and tick output
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the period: counter to 0, latch div_i
//   en          count enable
//   div_i       requested period in clk cycles (values below 2 act as 2)
//   tick        high for one cycle at the end of each period
module ad7606_period_gen
  import ad7606_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 909
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_sat;

  // A period of 1 would tick every cycle and starve the capture state.
  assign div_sat = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
  assign tick    = en && !clear && (cnt == div_lat - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_lat <= DIV_W'(DEF_DIV);
    end else if (clear || tick) begin
      // The divider is only picked up on a period boundary so a period is never cut short.
      cnt     <= '0;
      div_lat <= div_sat;
    end else if (en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ad7606_sample_sched.sv
// rtl/ad7606_sample_sched.sv - AD7606 config, conversion-request and channel-capture sequencer
// Optional build macro: AD7606_SCHED_TIMEOUT_EN adds a capture watchdog and the tmo_o port.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   en_i, div_i, os_i, range_i    enable, sample period, oversampling code, range select
//   cfg_wr_i, clr_i               reprogram request, sticky flag clear
//   cfg_wr_n_o, cfg_data_o        config strobe (active low) and word to the core
//   conv_req_o                    one-cycle conversion request
//   data_i, sync_i, data_rd_ready_i  core word, channel-0 marker, word strobe
//   smp_data_o, smp_ch_o, smp_vld_o  tagged sample stream
//   frame_done_o                  pulses with the last channel of a frame
//   overrun_o, desync_o, tmo_o    sticky status flags
//   busy_o                        high outside IDLE
module ad7606_sample_sched
  import ad7606_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 909,
  parameter int TMO_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic [2:0]          os_i,
  input  logic                range_i,
  input  logic                cfg_wr_i,
  input  logic                clr_i,
  output logic                cfg_wr_n_o,
  output logic [15:0]         cfg_data_o,
  output logic                conv_req_o,
  input  logic [15:0]         data_i,
  input  logic                sync_i,
  input  logic                data_rd_ready_i,
  output logic [15:0]         smp_data_o,
  output logic [CH_IDX_W-1:0] smp_ch_o,
  output logic                smp_vld_o,
  output logic                frame_done_o,
  output logic                overrun_o,
  output logic                desync_o,
`ifdef AD7606_SCHED_TIMEOUT_EN
  output logic                tmo_o,
`endif
  output logic                busy_o
);

  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(CH_NUM - 1);

  state_t              state;
  logic [CH_IDX_W-1:0] idx;
  logic                cfg_pend;
  logic                tick;
  logic [CH_IDX_W-1:0] word_ch;
  logic                word_acc;
  logic                last_word;
  logic                tmo_hit;

  ad7606_period_gen #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_period (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_CFG),
    .en    ((state == ST_WAIT) || (state == ST_CAP)),
    .div_i (div_i),
    .tick  (tick)
  );

  // A sync strobe re-aligns the frame: the word it qualifies is always channel 0.
  assign word_ch   = sync_i ? '0 : idx;
  assign word_acc  = (state == ST_CAP) && data_rd_ready_i;
  assign last_word = word_acc && (word_ch == LAST_CH);
  assign busy_o    = (state != ST_IDLE);

`ifdef AD7606_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC) + 1;
  logic [TMO_W-1:0] tmo_cnt;

  // A frame that completes on the watchdog's last cycle still counts as complete.
  assign tmo_hit = (state == ST_CAP) && !last_word && (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_o   <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_CAP) ? tmo_cnt + TMO_W'(1) : '0;
      if (clr_i)   tmo_o <= 1'b0;
      if (tmo_hit) tmo_o <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cfg_pend     <= 1'b0;
      cfg_wr_n_o   <= 1'b1;
      cfg_data_o   <= '0;
      conv_req_o   <= 1'b0;
      smp_data_o   <= '0;
      smp_ch_o     <= '0;
      smp_vld_o    <= 1'b0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
      desync_o     <= 1'b0;
    end else begin
      conv_req_o   <= 1'b0;
      smp_vld_o    <= 1'b0;
      frame_done_o <= 1'b0;
      cfg_wr_n_o   <= 1'b1;

      // Clear first so that a set later in this block wins.
      if (clr_i) begin
        overrun_o <= 1'b0;
        desync_o  <= 1'b0;
      end
      if (cfg_wr_i && (state != ST_IDLE)) cfg_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (en_i) begin
            state      <= ST_CFG;
            cfg_wr_n_o <= 1'b0;
            cfg_data_o <= cfg_word(os_i, range_i);
            cfg_pend   <= 1'b0;
          end
        end

        ST_CFG: state <= ST_WAIT;

        ST_WAIT: begin
          if (!en_i) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (cfg_pend) begin
              // The reprogram consumes this period; no conversion is requested.
              state      <= ST_CFG;
              cfg_wr_n_o <= 1'b0;
              cfg_data_o <= cfg_word(os_i, range_i);
              cfg_pend   <= 1'b0;
            end else begin
              state      <= ST_CAP;
              conv_req_o <= 1'b1;
              idx        <= '0;
            end
          end
        end

        ST_CAP: begin
          // The period keeps running; a tick here is simply a lost sample.
          if (tick) overrun_o <= 1'b1;
          if (word_acc) begin
            smp_data_o <= data_i;
            smp_ch_o   <= word_ch;
            smp_vld_o  <= 1'b1;
            idx        <= word_ch + CH_IDX_W'(1);
            if (sync_i && (idx != '0)) desync_o <= 1'b1;
            if (last_word) begin
              frame_done_o <= 1'b1;
              state        <= en_i ? ST_WAIT : ST_IDLE;
            end
          end
          if (tmo_hit) state <= en_i ? ST_WAIT : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7606_sample_sched.sv
// tb/tb_ad7606_sample_sched.sv - directed self-checking bench for ad7606_sample_sched
module tb_ad7606_sample_sched;

  localparam int CH_NUM  = 8;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 909;
  localparam int TMO_CYC = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en_i;
  logic [DIV_W-1:0] div_i;
  logic [2:0]       os_i;
  logic             range_i;
  logic             cfg_wr_i;
  logic             clr_i;
  logic             cfg_wr_n_o;
  logic [15:0]      cfg_data_o;
  logic             conv_req_o;
  logic [15:0]      data_i;
  logic             sync_i;
  logic             data_rd_ready_i;
  logic [15:0]      smp_data_o;
  logic [2:0]       smp_ch_o;
  logic             smp_vld_o;
  logic             frame_done_o;
  logic             overrun_o;
  logic             desync_o;
  logic             busy_o;
`ifdef AD7606_SCHED_TIMEOUT_EN
  logic             tmo_o;
`endif

  always #5 clk = ~clk;

  ad7606_sample_sched #(
    .CH_NUM  (CH_NUM),
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_i            (en_i),
    .div_i           (div_i),
    .os_i            (os_i),
    .range_i         (range_i),
    .cfg_wr_i        (cfg_wr_i),
    .clr_i           (clr_i),
    .cfg_wr_n_o      (cfg_wr_n_o),
    .cfg_data_o      (cfg_data_o),
    .conv_req_o      (conv_req_o),
    .data_i          (data_i),
    .sync_i          (sync_i),
    .data_rd_ready_i (data_rd_ready_i),
    .smp_data_o      (smp_data_o),
    .smp_ch_o        (smp_ch_o),
    .smp_vld_o       (smp_vld_o),
    .frame_done_o    (frame_done_o),
    .overrun_o       (overrun_o),
    .desync_o        (desync_o),
`ifdef AD7606_SCHED_TIMEOUT_EN
    .tmo_o           (tmo_o),
`endif
    .busy_o          (busy_o)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    conv_cnt = 0;
  int    fd_cnt = 0;
  longint t_last = 0;
  int    last_gap = 0;
  int    exp_fd = 0;

  // Event counters; read by the main thread only #1 after a falling edge.
  always @(negedge clk) begin
    if (conv_req_o === 1'b1)   conv_cnt++;
    if (frame_done_o === 1'b1) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next conversion request and records the distance from the previous one.
  task automatic wait_conv(input string tag);
    int k;
    k = 0;
    while (conv_req_o !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " conv seen"}, 32'(k < 2000), 32'd1);
    last_gap = int'(($time - t_last) / 10);
    t_last   = $time;
  endtask

  // Plays the core side of one frame, checking each tagged word as it comes out.
  task automatic frame(input int spacing, input logic [15:0] sync_mask, input int drop_at,
                       input string tag);
    int         w;
    int         exp_idx;
    logic [2:0] exp_ch;
    bit         done;
    w = 0; exp_idx = 0; done = 0;
    while (!done && w < 16) begin
      if (w == drop_at) en_i = 1'b0;
      data_i          = 16'h1000 + 16'(w);
      sync_i          = sync_mask[w];
      data_rd_ready_i = 1'b1;
      @(negedge clk);
      data_rd_ready_i = 1'b0;
      sync_i          = 1'b0;
      exp_ch  = sync_mask[w] ? 3'd0 : 3'(exp_idx);
      exp_idx = int'(exp_ch) + 1;
      done    = (int'(exp_ch) == CH_NUM - 1);
      chk($sformatf("%s w%0d vld", tag, w), 32'(smp_vld_o), 32'd1);
      chk($sformatf("%s w%0d ch", tag, w), 32'(smp_ch_o), 32'(exp_ch));
      chk($sformatf("%s w%0d data", tag, w), 32'(smp_data_o), 32'h1000 + 32'(w));
      chk($sformatf("%s w%0d fd", tag, w), 32'(frame_done_o), 32'(done));
      if (done) exp_fd++;
      w++;
      if (!done) cyc_n(spacing - 1);
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; en_i = 1'b0; div_i = 16'd100; os_i = 3'd0; range_i = 1'b0;
    cfg_wr_i = 1'b0; clr_i = 1'b0; data_i = '0; sync_i = 1'b0; data_rd_ready_i = 1'b0;
    cyc_n(3);
    chk("rst cfg_wr_n", 32'(cfg_wr_n_o), 32'd1);
    chk("rst cfg_data", 32'(cfg_data_o), 32'd0);
    chk("rst conv_req", 32'(conv_req_o), 32'd0);
    chk("rst smp", {smp_vld_o, frame_done_o, smp_ch_o, smp_data_o}, 32'd0);
    chk("rst flags", {overrun_o, desync_o, busy_o}, 32'd0);
    rst_n = 1'b1;
    cyc_n(2);

    // Strobe while IDLE must not produce a sample.
    data_rd_ready_i = 1'b1;
    cyc_n(1);
    data_rd_ready_i = 1'b0;
    chk("idle strobe vld", 32'(smp_vld_o), 32'd0);

    // Config sequence.
    os_i = 3'b010; range_i = 1'b1; en_i = 1'b1;
    cyc_n(1);
    chk("cfg strobe", 32'(cfg_wr_n_o), 32'd0);
    chk("cfg word", 32'(cfg_data_o), 32'h000A);
    chk("cfg busy", 32'(busy_o), 32'd1);
    cyc_n(1);
    chk("cfg strobe end", 32'(cfg_wr_n_o), 32'd1);
    chk("cfg word held", 32'(cfg_data_o), 32'h000A);
    t_last = $time;

    // Periodic conversion at div 100.
    wait_conv("p1");
    chk("p1 gap", 32'(last_gap), 32'd100);
    frame(1, 16'h0001, -1, "f1");
    data_rd_ready_i = 1'b1;
    cyc_n(1);
    data_rd_ready_i = 1'b0;
    chk("wait strobe vld", 32'(smp_vld_o), 32'd0);
    wait_conv("p2");
    chk("p2 gap", 32'(last_gap), 32'd100);
    frame(3, 16'h0001, -1, "f2");
    chk("no overrun yet", 32'(overrun_o), 32'd0);

    // Overrun: period 20, frame about 30 cycles long.
    div_i = 16'd20;
    wait_conv("p3");
    chk("p3 gap", 32'(last_gap), 32'd100);
    frame(4, 16'h0001, -1, "f3");
    chk("overrun set", 32'(overrun_o), 32'd1);
    wait_conv("p4");
    chk("p4 gap skip", 32'(last_gap), 32'd40);
    frame(4, 16'h0001, -1, "f4");
    wait_conv("p5");
    chk("p5 gap skip", 32'(last_gap), 32'd40);
    frame(1, 16'h0001, -1, "f5");
    chk("overrun sticky", 32'(overrun_o), 32'd1);
    clr_i = 1'b1;
    cyc_n(1);
    clr_i = 1'b0;
    chk("overrun cleared", 32'(overrun_o), 32'd0);
    div_i = 16'd100;
    wait_conv("p6");
    chk("p6 gap", 32'(last_gap), 32'd20);
    frame(1, 16'h0001, -1, "f6");

    // Desync: sync on words 0 and 2.
    wait_conv("p7");
    chk("p7 gap", 32'(last_gap), 32'd100);
    frame(1, 16'h0005, -1, "f7");
    chk("desync set", 32'(desync_o), 32'd1);
    chk("overrun quiet", 32'(overrun_o), 32'd0);
    wait_conv("p8");
    chk("p8 gap", 32'(last_gap), 32'd100);
    frame(1, 16'h0001, -1, "f8");
    clr_i = 1'b1;
    cyc_n(1);
    clr_i = 1'b0;
    chk("desync cleared", 32'(desync_o), 32'd0);

    // Reconfig request during capture.
    wait_conv("p9");
    os_i = 3'b101; range_i = 1'b0; cfg_wr_i = 1'b1;
    cyc_n(1);
    cfg_wr_i = 1'b0;
    frame(1, 16'h0001, -1, "f9");
    #1 c0 = conv_cnt;
    begin
      int k;
      k = 0;
      while (cfg_wr_n_o !== 1'b0 && k < 300) begin
        @(negedge clk);
        k++;
      end
      chk("recfg strobe seen", 32'(k < 300), 32'd1);
    end
    chk("recfg word", 32'(cfg_data_o), 32'h0005);
    chk("recfg at tick", 32'(int'(($time - t_last) / 10)), 32'd100);
    t_last = $time;
    #1 chk("recfg no conv", 32'(conv_cnt), 32'(c0));
    wait_conv("p10");
    chk("p10 gap after cfg", 32'(last_gap), 32'd101);
    frame(1, 16'h0001, -1, "f10");
    wait_conv("p11");
    chk("p11 gap", 32'(last_gap), 32'd100);

    // Disable mid-frame: frame completes, then IDLE.
    frame(1, 16'h0001, 3, "f11");
    chk("disable busy", 32'(busy_o), 32'd0);
    #1 c0 = conv_cnt;
    cyc_n(150);
    #1 chk("disable no conv", 32'(conv_cnt), 32'(c0));
    chk("frame_done count", 32'(fd_cnt), 32'(exp_fd));

`ifdef AD7606_SCHED_TIMEOUT_EN
    en_i = 1'b1;
    wait_conv("t1");
    for (int i = 0; i < 3; i++) begin
      data_i = 16'h2000 + 16'(i); sync_i = (i == 0); data_rd_ready_i = 1'b1;
      @(negedge clk);
    end
    data_rd_ready_i = 1'b0; sync_i = 1'b0;
    cyc_n(60);
    chk("tmo before", 32'(tmo_o), 32'd0);
    cyc_n(1);
    chk("tmo set", 32'(tmo_o), 32'd1);
    chk("tmo busy", 32'(busy_o), 32'd1);
    #1 chk("tmo no frame_done", 32'(fd_cnt), 32'(exp_fd));
    wait_conv("t2");
    chk("t2 gap", 32'(last_gap), 32'd100);
    frame(1, 16'h0001, -1, "ft");
    clr_i = 1'b1;
    cyc_n(1);
    clr_i = 1'b0;
    chk("tmo cleared", 32'(tmo_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
